// File: rtl/ibex_csr_shadow_bank_if.sv
// Write/read bus of the shadowed CSR bank: the master issues single-cycle write
// requests and a read address; the slave returns the committed value and its integrity flag.
interface ibex_csr_shadow_bank_if #(
  parameter int unsigned Width = 32,
  parameter int unsigned AddrW = 2
) ();
  logic             wr_en_i;
  logic [AddrW-1:0] wr_addr_i;
  logic [1:0]       wr_op_i;
  logic [Width-1:0] wr_data_i;
  logic [AddrW-1:0] rd_addr_i;
  logic [Width-1:0] rd_data_o;
  logic             rd_error_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_op_i, wr_data_i, rd_addr_i,
    input  rd_data_o, rd_error_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_op_i, wr_data_i, rd_addr_i,
    output rd_data_o, rd_error_o
  );
endinterface

// File: rtl/ibex_csr_shadow_bank.sv
// Bank of shadowed CSRs: each register needs two identical writes to commit, keeps an
// inverted shadow copy for storage-fault detection, and can be locked until reset.
module ibex_csr_shadow_bank #(
  parameter int unsigned              Width       = 32,
  parameter int unsigned              NumRegs     = 4,
  parameter logic [NumRegs*Width-1:0] ResetValues = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  ibex_csr_shadow_bank_if.slave        bus,
  input  logic [NumRegs-1:0]           lock_set_i,
  output logic [NumRegs-1:0]           phase_o,
  output logic [NumRegs-1:0]           locked_o,
  output logic                         commit_o,
  output logic                         upd_err_o,
  output logic                         store_err_o
);
  localparam int unsigned AddrW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  typedef enum logic {IDLE = 1'b0, STAGED = 1'b1} phase_e;

  phase_e                          state_q [NumRegs];
  phase_e                          state_d [NumRegs];
  logic [NumRegs-1:0][Width-1:0]   primary_q, primary_d;
  logic [NumRegs-1:0][Width-1:0]   shadow_q, shadow_d;
  logic [NumRegs-1:0][Width-1:0]   staged_q, staged_d;
  logic [NumRegs-1:0]              locked_q, locked_d;
  logic [NumRegs-1:0]              mismatch;
  logic                            commit_q, commit_d;
  logic                            upd_err_q, upd_err_d;
  logic                            store_err_q, store_err_d;

  logic             addr_ok;
  logic             locked_tgt;
  logic [Width-1:0] cur_val;
  logic [Width-1:0] new_val;
  logic             wr_valid;

  // Decode the request; the op is applied to the committed value, never the staged one.
  always_comb begin
    addr_ok    = 1'b0;
    locked_tgt = 1'b0;
    cur_val    = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (bus.wr_addr_i == AddrW'(i)) begin
        addr_ok    = 1'b1;
        locked_tgt = locked_q[i];
        cur_val    = primary_q[i];
      end
    end
    case (bus.wr_op_i)
      2'b01:   new_val = cur_val | bus.wr_data_i;
      2'b10:   new_val = cur_val & ~bus.wr_data_i;
      default: new_val = bus.wr_data_i;
    endcase
    wr_valid = bus.wr_en_i && addr_ok && (bus.wr_op_i != 2'b11) && !locked_tgt;
  end

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      mismatch[i] = (primary_q[i] != ~shadow_q[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    primary_d   = primary_q;
    shadow_d    = shadow_q;
    staged_d    = staged_q;
    commit_d    = 1'b0;
    upd_err_d   = bus.wr_en_i && !wr_valid;
    locked_d    = locked_q | lock_set_i;
    store_err_d = store_err_q | (|mismatch);
    for (int i = 0; i < NumRegs; i++) begin
      if (wr_valid && (bus.wr_addr_i == AddrW'(i))) begin
        if (state_q[i] == IDLE) begin
          staged_d[i] = new_val;
          state_d[i]  = STAGED;
        end else begin
          if (new_val == staged_q[i]) begin
            primary_d[i] = new_val;
            shadow_d[i]  = ~new_val;
            commit_d     = 1'b1;
          end else begin
            upd_err_d = 1'b1;
          end
          state_d[i] = IDLE;
        end
      end
      // A lock request wins over a first write but not over a completing second write.
      if (lock_set_i[i]) begin
        state_d[i] = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) begin
        primary_q[i] <= ResetValues[i*Width +: Width];
        shadow_q[i]  <= ~ResetValues[i*Width +: Width];
        state_q[i]   <= IDLE;
      end
      staged_q    <= '0;
      locked_q    <= '0;
      commit_q    <= 1'b0;
      upd_err_q   <= 1'b0;
      store_err_q <= 1'b0;
    end else begin
      primary_q   <= primary_d;
      shadow_q    <= shadow_d;
      state_q     <= state_d;
      staged_q    <= staged_d;
      locked_q    <= locked_d;
      commit_q    <= commit_d;
      upd_err_q   <= upd_err_d;
      store_err_q <= store_err_d;
    end
  end

  always_comb begin
    bus.rd_data_o  = '0;
    bus.rd_error_o = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      phase_o[i] = (state_q[i] == STAGED);
      if (bus.rd_addr_i == AddrW'(i)) begin
        bus.rd_data_o  = primary_q[i];
        bus.rd_error_o = mismatch[i];
      end
    end
  end

  assign locked_o    = locked_q;
  assign commit_o    = commit_q;
  assign upd_err_o   = upd_err_q;
  assign store_err_o = store_err_q;
endmodule

// File: tb/tb_ibex_csr_shadow_bank.sv
// Bench for ibex_csr_shadow_bank: vector table of writes with a scoreboard of expected
// pulses/readback, plus hand-written lock, storage-corruption and reset sequences.
module tb_ibex_csr_shadow_bank;
  localparam logic [127:0] RST_VALS = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};

  logic       clk;
  logic       rst_n;
  logic [3:0] lock_set;
  logic [3:0] phase;
  logic [3:0] locked;
  logic       commit;
  logic       upd_err;
  logic       store_err;

  ibex_csr_shadow_bank_if #(.Width(32), .AddrW(2)) bus ();

  ibex_csr_shadow_bank #(
    .Width(32), .NumRegs(4), .ResetValues(RST_VALS)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus.slave),
    .lock_set_i  (lock_set),
    .phase_o     (phase),
    .locked_o    (locked),
    .commit_o    (commit),
    .upd_err_o   (upd_err),
    .store_err_o (store_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
    logic [3:0]  lock;
    logic        commit;
    logic        err;
    logic        phase;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    int          idx;
    logic [1:0]  addr;
    logic        commit;
    logic        err;
    logic        phase;
    logic [31:0] rd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic [1:0] addr, input logic [1:0] op,
                              input logic [31:0] data, input logic [3:0] lock, input logic c,
                              input logic e, input logic p, input logic [31:0] rd);
    vec_t v;
    v.en = en; v.addr = addr; v.op = op; v.data = data; v.lock = lock;
    v.commit = c; v.err = e; v.phase = p; v.rd = rd;
    return v;
  endfunction

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    bus.wr_en_i   = v.en;
    bus.wr_addr_i = v.addr;
    bus.wr_op_i   = v.op;
    bus.wr_data_i = v.data;
    bus.rd_addr_i = v.addr;
    lock_set      = v.lock;
    e.idx = idx; e.addr = v.addr; e.commit = v.commit; e.err = v.err; e.phase = v.phase; e.rd = v.rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.wr_en_i = 1'b0;
    lock_set    = '0;
    got = sb.pop_front();
    chk($sformatf("v%0d commit", got.idx), {31'b0, commit}, {31'b0, got.commit});
    chk($sformatf("v%0d upd_err", got.idx), {31'b0, upd_err}, {31'b0, got.err});
    chk($sformatf("v%0d phase", got.idx), {31'b0, phase[got.addr]}, {31'b0, got.phase});
    chk($sformatf("v%0d rd_data", got.idx), bus.rd_data_o, got.rd);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " phase"}, {28'b0, phase}, 32'h0);
    chk({tag, " locked"}, {28'b0, locked}, 32'h0);
    chk({tag, " commit"}, {31'b0, commit}, 32'h0);
    chk({tag, " upd_err"}, {31'b0, upd_err}, 32'h0);
    chk({tag, " store_err"}, {31'b0, store_err}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr_i = 2'(a);
      #1;
      chk($sformatf("%s rd_data%0d", tag, a), bus.rd_data_o, RST_VALS[a*32 +: 32]);
      chk($sformatf("%s rd_error%0d", tag, a), {31'b0, bus.rd_error_o}, 32'h0);
    end
  endtask

  logic [3:0][31:0] bad_shadow;

  initial begin
    rst_n         = 1'b0;
    lock_set      = '0;
    bus.wr_en_i   = 1'b0;
    bus.wr_addr_i = '0;
    bus.wr_op_i   = '0;
    bus.wr_data_i = '0;
    bus.rd_addr_i = '0;

    //            en    addr op    data           lock  c  e  p  rd
    vecs.push_back(mk(1, 1, 0, 32'hA5A5_0001, 4'h0, 0, 0, 1, 32'h1111_0001));
    vecs.push_back(mk(1, 1, 0, 32'hA5A5_0001, 4'h0, 1, 0, 0, 32'hA5A5_0001));
    vecs.push_back(mk(1, 2, 0, 32'h0000_00F0, 4'h0, 0, 0, 1, 32'h2222_0002));
    vecs.push_back(mk(1, 2, 0, 32'h0000_00F0, 4'h0, 1, 0, 0, 32'h0000_00F0));
    vecs.push_back(mk(1, 2, 1, 32'h0000_000F, 4'h0, 0, 0, 1, 32'h0000_00F0));
    vecs.push_back(mk(1, 2, 1, 32'h0000_000F, 4'h0, 1, 0, 0, 32'h0000_00FF));
    vecs.push_back(mk(1, 2, 2, 32'h0000_00F0, 4'h0, 0, 0, 1, 32'h0000_00FF));
    vecs.push_back(mk(1, 2, 2, 32'h0000_00F0, 4'h0, 1, 0, 0, 32'h0000_000F));
    vecs.push_back(mk(1, 0, 0, 32'h0000_0001, 4'h0, 0, 0, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 0, 0, 32'h0000_0002, 4'h0, 0, 1, 0, 32'h0000_0000));
    vecs.push_back(mk(1, 1, 3, 32'h0000_FFFF, 4'h0, 0, 1, 0, 32'hA5A5_0001));
    vecs.push_back(mk(1, 0, 0, 32'h0000_0007, 4'h0, 0, 0, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 2, 0, 32'h0000_0055, 4'h0, 0, 0, 1, 32'h0000_000F));
    vecs.push_back(mk(1, 0, 0, 32'h0000_0007, 4'h0, 1, 0, 0, 32'h0000_0007));
    vecs.push_back(mk(1, 1, 0, 32'h0000_0009, 4'h0, 0, 0, 1, 32'hA5A5_0001));
    vecs.push_back(mk(1, 1, 3, 32'h0000_0009, 4'h0, 0, 1, 1, 32'hA5A5_0001));
    vecs.push_back(mk(1, 1, 0, 32'h0000_0009, 4'h0, 1, 0, 0, 32'h0000_0009));
    vecs.push_back(mk(0, 3, 0, 32'h0000_0000, 4'h8, 0, 0, 0, 32'h3333_0003));
    vecs.push_back(mk(1, 3, 0, 32'h0000_DEAD, 4'h0, 0, 1, 0, 32'h3333_0003));
    vecs.push_back(mk(1, 3, 1, 32'h0000_0001, 4'h0, 0, 1, 0, 32'h3333_0003));
    vecs.push_back(mk(1, 2, 0, 32'h0000_0055, 4'h4, 1, 0, 0, 32'h0000_0055));
    vecs.push_back(mk(1, 1, 0, 32'h0000_00AB, 4'h2, 0, 0, 0, 32'h0000_0009));
    vecs.push_back(mk(1, 1, 0, 32'h0000_00AB, 4'h0, 0, 1, 0, 32'h0000_0009));

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end
    chk("locked_after_table", {28'b0, locked}, 32'h0000_000E);
    chk("store_err_clean", {31'b0, store_err}, 32'h0);

    // Corrupt one bit of reg1's shadow copy.
    bad_shadow[0] = ~32'h0000_0007;
    bad_shadow[1] = ~32'h0000_0009 ^ 32'h0000_0010;
    bad_shadow[2] = ~32'h0000_0055;
    bad_shadow[3] = ~32'h3333_0003;
    @(negedge clk);
    force dut.shadow_q = bad_shadow;
    bus.rd_addr_i = 2'd1;
    #1;
    chk("rd_error_reg1", {31'b0, bus.rd_error_o}, 32'h1);
    chk("rd_data_reg1_corrupt", bus.rd_data_o, 32'h0000_0009);
    chk("store_err_not_yet", {31'b0, store_err}, 32'h0);
    bus.rd_addr_i = 2'd0;
    #1;
    chk("rd_error_reg0", {31'b0, bus.rd_error_o}, 32'h0);
    @(posedge clk);
    #1;
    chk("store_err_set", {31'b0, store_err}, 32'h1);
    @(negedge clk);
    release dut.shadow_q;
    repeat (3) @(posedge clk);
    #1;
    chk("store_err_sticky", {31'b0, store_err}, 32'h1);

    // Stage a first write, then reset in the same cycle as a rejected write.
    @(negedge clk);
    bus.wr_en_i = 1'b1; bus.wr_addr_i = 2'd0; bus.wr_op_i = 2'd0; bus.wr_data_i = 32'h77;
    @(posedge clk);
    #1;
    bus.wr_en_i = 1'b0;
    chk("pre_reset_phase0", {31'b0, phase[0]}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.wr_en_i = 1'b1; bus.wr_op_i = 2'd3;
    @(posedge clk);
    #1;
    bus.wr_en_i = 1'b0;
    check_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;

    // After reset a single write must only stage, not commit against stale state.
    apply(100, mk(1, 0, 0, 32'h0000_0077, 4'h0, 0, 0, 1, 32'h0000_0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
